// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - op request / result bundle between control unit and alu_seq
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [7:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cf;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] c;
  logic             c_flag;
  logic             z_flag;
  logic             o_flag;
  logic             err;

  modport master (
    output start, op, a, b, cf,
    input  busy, done, acc, c, c_flag, z_flag, o_flag, err
  );

  modport slave (
    input  start, op, a, b, cf,
    output busy, done, acc, c, c_flag, z_flag, o_flag, err
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU: single-cycle logic/arith ops plus a
// one-bit-per-cycle shift-add multiplier and restoring divider.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  localparam int HW = WIDTH / 2;
  localparam int CW = $clog2(WIDTH);

  localparam logic [7:0] OP_ADD  = 8'h01;
  localparam logic [7:0] OP_ADC  = 8'h02;
  localparam logic [7:0] OP_SUB  = 8'h03;
  localparam logic [7:0] OP_SUC  = 8'h04;
  localparam logic [7:0] OP_MULH = 8'h05;
  localparam logic [7:0] OP_MUL  = 8'h06;
  localparam logic [7:0] OP_DIVH = 8'h07;
  localparam logic [7:0] OP_DIV  = 8'h08;
  localparam logic [7:0] OP_CMP  = 8'h09;
  localparam logic [7:0] OP_AND  = 8'h0A;
  localparam logic [7:0] OP_NEG  = 8'h0B;
  localparam logic [7:0] OP_NOT  = 8'h0C;
  localparam logic [7:0] OP_OR   = 8'h0D;
  localparam logic [7:0] OP_SHL  = 8'h0E;
  localparam logic [7:0] OP_SHR  = 8'h0F;
  localparam logic [7:0] OP_XOR  = 8'h10;
  localparam logic [7:0] OP_TEST = 8'h11;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic             div_q;
  logic [WIDTH-1:0] opnd, work_hi, work_lo;

  logic [WIDTH-1:0] acc_q, c_q;
  logic             c_flag_q, z_flag_q, o_flag_q, err_q;

  logic             is_half, is_mul, is_div, div_zero, illegal, iter_op, accept, cin;
  logic [WIDTH-1:0] a_x, b_x, logic_r, hi_n, lo_n;
  logic [WIDTH:0]   add_r, sub_r, mul_sum, div_shift, div_diff;

  always_comb begin
    is_half  = (bus.op == OP_MULH) || (bus.op == OP_DIVH);
    is_mul   = (bus.op == OP_MULH) || (bus.op == OP_MUL);
    is_div   = (bus.op == OP_DIVH) || (bus.op == OP_DIV);
    a_x      = is_half ? {{(WIDTH-HW){1'b0}}, bus.a[HW-1:0]} : bus.a;
    b_x      = is_half ? {{(WIDTH-HW){1'b0}}, bus.b[HW-1:0]} : bus.b;
    div_zero = is_div && (b_x == '0);
    illegal  = (bus.op == 8'h00) || (bus.op > OP_TEST);
    iter_op  = is_mul || (is_div && !div_zero);
    accept   = bus.start && (state != RUN);
    cin      = ((bus.op == OP_ADC) || (bus.op == OP_SUC)) && bus.cf;
    add_r    = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, cin};
    sub_r    = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, cin};
    logic_r  = '0;
    case (bus.op)
      OP_AND:  logic_r = bus.a & bus.b;
      OP_NEG:  logic_r = ~bus.a;
      OP_NOT:  logic_r = {{(WIDTH-1){1'b0}}, (bus.a == '0)};
      OP_OR:   logic_r = bus.a | bus.b;
      OP_SHL:  logic_r = {bus.a[WIDTH-2:0], 1'b0};
      OP_SHR:  logic_r = {1'b0, bus.a[WIDTH-1:1]};
      OP_XOR:  logic_r = bus.a ^ bus.b;
      default: logic_r = '0;
    endcase
  end

  // {work_hi, work_lo} is the product shifting right, or remainder:quotient shifting left
  always_comb begin
    mul_sum   = {1'b0, work_hi} + {1'b0, opnd & {WIDTH{work_lo[0]}}};
    div_shift = {work_hi, work_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    hi_n      = mul_sum[WIDTH:1];
    lo_n      = {mul_sum[0], work_lo[WIDTH-1:1]};
    if (div_q) begin
      hi_n = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      lo_n = {work_lo[WIDTH-2:0], ~div_diff[WIDTH]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: begin
        if (bus.start) state_nxt = iter_op ? RUN : FIN;
        else           state_nxt = IDLE;
      end
      RUN:     if (cnt == '0) state_nxt = FIN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      div_q    <= 1'b0;
      opnd     <= '0;
      work_hi  <= '0;
      work_lo  <= '0;
      acc_q    <= '0;
      c_q      <= '0;
      c_flag_q <= 1'b0;
      z_flag_q <= 1'b0;
      o_flag_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      if (iter_op) begin
        div_q   <= is_div;
        opnd    <= is_div ? b_x : a_x;
        work_hi <= '0;
        work_lo <= is_div ? a_x : b_x;
        cnt     <= CW'(WIDTH - 1);
      end else if (illegal) begin
        err_q <= 1'b1;
      end else if (div_zero) begin
        acc_q    <= '1;
        c_q      <= a_x;
        z_flag_q <= 1'b0;
        err_q    <= 1'b1;
      end else begin
        err_q <= 1'b0;
        case (bus.op)
          OP_ADD, OP_ADC: begin
            acc_q    <= add_r[WIDTH-1:0];
            c_flag_q <= add_r[WIDTH];
            o_flag_q <= (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_r[WIDTH-1] != bus.a[WIDTH-1]);
            z_flag_q <= (add_r[WIDTH-1:0] == '0);
          end
          OP_SUB, OP_SUC: begin
            acc_q    <= sub_r[WIDTH-1:0];
            c_flag_q <= sub_r[WIDTH];
            o_flag_q <= (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_r[WIDTH-1] != bus.a[WIDTH-1]);
            z_flag_q <= (sub_r[WIDTH-1:0] == '0);
          end
          OP_CMP: begin
            z_flag_q <= (bus.a == bus.b);
            c_flag_q <= (bus.a < bus.b);
            o_flag_q <= (bus.a > bus.b);
          end
          OP_TEST: z_flag_q <= (bus.a == bus.b);
          OP_SHL, OP_SHR: begin
            acc_q    <= logic_r;
            c_flag_q <= (bus.op == OP_SHL) ? bus.a[WIDTH-1] : bus.a[0];
            z_flag_q <= (logic_r == '0);
          end
          default: begin
            acc_q    <= logic_r;
            z_flag_q <= (logic_r == '0);
          end
        endcase
      end
    end else if (state == RUN) begin
      work_hi <= hi_n;
      work_lo <= lo_n;
      cnt     <= cnt - CW'(1);
      // results are published only on the last step so acc/c never show partials
      if (cnt == '0) begin
        acc_q    <= lo_n;
        c_q      <= hi_n;
        z_flag_q <= div_q ? (lo_n == '0) : ({hi_n, lo_n} == '0);
        err_q    <= 1'b0;
      end
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == FIN);
  assign bus.acc    = acc_q;
  assign bus.c      = c_q;
  assign bus.c_flag = c_flag_q;
  assign bus.z_flag = z_flag_q;
  assign bus.o_flag = o_flag_q;
  assign bus.err    = err_q;
endmodule
